cyphertext_reader: RTL and testbench

- Drains stored cyphertext blocks from the cyphertext RAM read port and streams them out as bytes over a valid/ready interface. Typical sinks are a UART or host FIFO.
- It is the consumer side of the RAM that the encryption core fills on each finish pulse.
- Reads a contiguous run of blocks starting at a given address. Serializes each TEXT_WIDTH-bit block MSB byte first.

---
 rtl/cyphertext_reader.sv | 112 +++++++++++
 tb/tb_cyphertext_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cyphertext_reader.sv
// Cyphertext RAM readout: fetches a contiguous run of blocks from the RAM
// read port and streams each block out MSB byte first over valid/ready.
module cyphertext_reader #(
  parameter int TEXT_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 4,
  parameter int MEMORY_SIZE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] first_addr_i,
  input  logic [ADDR_WIDTH:0]   num_blocks_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [TEXT_WIDTH-1:0] rd_data_i,
  output logic [7:0]            byte_o,
  output logic                  byte_valid_o,
  input  logic                  byte_ready_i,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BYTES = TEXT_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_FINISH
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     blk_q, blk_d;
  logic [BCW-1:0]          bcnt_q, bcnt_d;
  logic [TEXT_WIDTH-1:0]   shift_q, shift_d;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic                    xfer;

  // Address advances modulo MEMORY_SIZE, which need not be a power of two.
  assign addr_next = (addr_q == ADDR_WIDTH'(MEMORY_SIZE - 1)) ? '0 : addr_q + 1'b1;
  assign xfer      = (state_q == S_SEND) && byte_ready_i;

  // Outputs are decoded from registered state only.
  assign rd_en_o      = (state_q == S_FETCH);
  assign rd_addr_o    = addr_q;
  assign byte_valid_o = (state_q == S_SEND);
  assign byte_o       = byte_valid_o ? shift_q[TEXT_WIDTH-1 -: 8] : 8'h00;
  assign last_o       = byte_valid_o && (blk_q == (ADDR_WIDTH+1)'(1)) && (bcnt_q == '0);
  assign busy_o       = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_SEND);
  assign done_o       = (state_q == S_FINISH);

  // Next-state and datapath update; everything holds unless a state says otherwise.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    blk_d   = blk_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = first_addr_i;
          blk_d   = num_blocks_i;
          state_d = (num_blocks_i == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        // RAM data is valid the cycle after the read strobe.
        shift_d = rd_data_i;
        bcnt_d  = BCW'(BYTES - 1);
        state_d = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          if (bcnt_q == '0) begin
            blk_d   = blk_q - 1'b1;
            addr_d  = addr_next;
            state_d = (blk_q == (ADDR_WIDTH+1)'(1)) ? S_FINISH : S_FETCH;
          end else begin
            shift_d = shift_q << 8;
            bcnt_d  = bcnt_q - 1'b1;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any readout in progress without a done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      blk_q   <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      blk_q   <= blk_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: tb/tb_cyphertext_reader.sv
// Scoreboard bench for cyphertext_reader: stimulus pushes expected reads and
// bytes into queues, a negedge monitor compares whatever the DUT presents.
module tb_cyphertext_reader;
  localparam int TW = 128;
  localparam int AW = 4;
  localparam int MS = 16;

  logic          clk = 1'b0;
  logic          rst, start, rd_en, byte_valid, ready, last, busy, done;
  logic [AW-1:0] first_addr, rd_addr;
  logic [AW:0]   num_blocks;
  logic [TW-1:0] rd_data;
  logic [7:0]    byte_out;

  cyphertext_reader #(.TEXT_WIDTH(TW), .ADDR_WIDTH(AW), .MEMORY_SIZE(MS)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .first_addr_i(first_addr),
    .num_blocks_i(num_blocks), .rd_en_o(rd_en), .rd_addr_o(rd_addr),
    .rd_data_i(rd_data), .byte_o(byte_out), .byte_valid_o(byte_valid),
    .byte_ready_i(ready), .last_o(last), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  logic [TW-1:0] mem [MS];
  logic [8:0]    exp_q [$];   // {last, byte}
  logic [AW-1:0] addr_q [$];
  int checks = 0, errors = 0, cyc = 0;
  int done_cnt = 0, done_cyc = -1, gap = 0, first_v = -1, nbytes = 0, nrd = 0, busy_seen = 0;
  bit bp_mode = 1'b0;
  int bpcnt = 0;
  logic [8:0]    mon_e;
  logic [AW-1:0] mon_a;

  // RAM model with one-cycle read latency, plus a cycle counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: compares reads and presented bytes against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_seen++;
      if (busy && !byte_valid) gap++;
      if (rd_en) begin
        nrd++;
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL rd_addr: unexpected read at %0d", rd_addr);
        end else begin
          mon_a = addr_q.pop_front();
          if (mon_a !== rd_addr) begin
            errors++;
            $display("FAIL rd_addr: got %0d expected %0d", rd_addr, mon_a);
          end
        end
      end
      if (byte_valid) begin
        if (first_v < 0) first_v = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte: unexpected byte %h", byte_out);
        end else begin
          mon_e = exp_q[0];
          if ({last, byte_out} !== mon_e) begin
            errors++;
            $display("FAIL byte: got last=%b byte=%h expected last=%b byte=%h",
                     last, byte_out, mon_e[8], mon_e[7:0]);
          end
          if (ready) begin
            void'(exp_q.pop_front());
            nbytes++;
          end
        end
      end else if (last) begin
        checks++;
        errors++;
        $display("FAIL last_idle: got 1 expected 0");
      end
    end
  end

  // Backpressure pattern 1,0,0,1 repeating.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        ready = ((bpcnt % 4) == 0) || ((bpcnt % 4) == 3);
        bpcnt++;
      end
    end
  end

  // Queue expectations and pulse start; s = cycle value right after the sampling edge.
  task automatic start_run(input int f, input int n, output int s);
    logic [TW-1:0] blk;
    int a;
    gap = 0; first_v = -1; nbytes = 0; nrd = 0; busy_seen = 0;
    for (int b = 0; b < n; b++) begin
      a = (f + b) % MS;
      addr_q.push_back(AW'(a));
      blk = mem[a];
      for (int k = 0; k < TW/8; k++)
        exp_q.push_back({(b == n-1) && (k == TW/8-1), blk[TW-1-8*k -: 8]});
    end
    @(posedge clk); #1;
    start = 1'b1; first_addr = AW'(f); num_blocks = (AW+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int d0);
    int i;
    for (i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
    chk("done_timeout", (done_cnt != d0), 1);
    chk("exp_bytes_left", exp_q.size(), 0);
    chk("exp_reads_left", addr_q.size(), 0);
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_rd_en"}, rd_en, 0);
    chk({nm, "_rd_addr"}, rd_addr, 0);
    chk({nm, "_byte"}, byte_out, 0);
    chk({nm, "_valid"}, byte_valid, 0);
    chk({nm, "_last"}, last, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  initial begin
    int s, d0;
    rst = 1'b1; start = 1'b0; first_addr = '0; num_blocks = '0; ready = 1'b0; rd_data = '0;
    for (int i = 0; i < MS; i++) mem[i] = '0;
    mem[3]  = 128'h00112233445566778899AABBCCDDEEFF;
    mem[15] = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    mem[0]  = 128'h0123456789ABCDEFFEDCBA9876543210;
    mem[7]  = 128'hDEADBEEFCAFEF00D0BADC0DE12345678;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;
    ready = 1'b1;

    // Single block, full throughput
    d0 = done_cnt;
    start_run(3, 1, s);
    wait_done(d0);
    chk("single_first_valid", first_v, s + 2);
    chk("single_done_cyc", done_cyc, s + 18);
    chk("single_gap", gap, 2);
    chk("single_reads", nrd, 1);
    chk("single_bytes", nbytes, 16);

    // Backpressure
    bp_mode = 1'b1; bpcnt = 0;
    d0 = done_cnt;
    start_run(3, 1, s);
    wait_done(d0);
    chk("bp_bytes", nbytes, 16);
    chk("bp_reads", nrd, 1);
    bp_mode = 1'b0;
    @(posedge clk); #1;
    ready = 1'b1;

    // Wrap-around 15 -> 0
    d0 = done_cnt;
    start_run(15, 2, s);
    wait_done(d0);
    chk("wrap_gap", gap, 4);
    chk("wrap_bytes", nbytes, 32);
    chk("wrap_reads", nrd, 2);
    chk("wrap_done_cyc", done_cyc, s + 36);

    // Zero blocks
    d0 = done_cnt;
    start_run(5, 0, s);
    wait_done(d0);
    chk("zero_done_cyc", done_cyc, s);
    chk("zero_busy", busy_seen, 0);
    chk("zero_reads", nrd, 0);
    chk("zero_bytes", nbytes, 0);
    chk("zero_valid", first_v, -1);

    // Ignored start in SEND, then reset mid-block
    d0 = done_cnt;
    start_run(7, 1, s);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; first_addr = 4'd2; num_blocks = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("abort");
    rst = 1'b0;
    chk("abort_reads", nrd, 1);
    exp_q.delete();
    addr_q.delete();
    repeat (4) @(posedge clk);
    chk("abort_no_done", done_cnt, d0);
    ready = 1'b1;
    start_run(3, 1, s);
    wait_done(d0);
    chk("restart_first_valid", first_v, s + 2);
    chk("restart_bytes", nbytes, 16);

    // Full memory drain
    for (int i = 0; i < MS; i++) mem[i] = {16{8'(i)}};
    d0 = done_cnt;
    start_run(0, 16, s);
    wait_done(d0);
    repeat (5) @(posedge clk);
    chk("drain_done_once", done_cnt - d0, 1);
    chk("drain_bytes", nbytes, 256);
    chk("drain_reads", nrd, 16);
    chk("drain_gap", gap, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
